// File: rtl/csr_pkg.sv
// Shared CSR definitions: decoded addresses, modify encodings, UART status bits
// and the transmit FSM state type.
package csr_pkg;

    localparam logic [11:0] CSR_UART = 12'hbc0;
    localparam logic [11:0] CSR_SIM  = 12'h3ff;

    typedef enum logic [2:0] {
        MOD_NONE  = 3'd0,
        MOD_WRITE = 3'd1,
        MOD_SET   = 3'd2,
        MOD_CLEAR = 3'd3
    } csr_mod_e;

    localparam int unsigned UART_ST_FULL = 8;
    localparam int unsigned UART_ST_BUSY = 9;
    localparam int unsigned UART_ST_OVF  = 10;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, depth 2**AW, with occupancy count; pushes when full and
// pops when empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int unsigned DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/csr_uart_tx.sv
// CSR-mapped 8N1 UART transmitter: byte writes are queued in a FIFO and sent
// on uart_tx; reads return full/busy/overflow status.
module csr_uart_tx
    import csr_pkg::*;
#(
    parameter logic [11:0] CSR_ADDR = CSR_UART,
    parameter int unsigned BAUD_DIV = 24,
    parameter int unsigned FIFO_AW  = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        csr_read,
    input  logic [11:0] csr_addr,
    input  logic [2:0]  csr_modify,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_valid,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    logic [11:0]      q_addr;
    logic             q_rd;
    logic             sel;
    logic             wr_req;
    logic             clr_req;
    logic             ovf_q;

    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;

    tx_state_e        state_q;
    tx_state_e        state_d;
    logic [15:0]      baud_cnt;
    logic             bit_end;
    logic [2:0]       idx;
    logic [7:0]       shift;

    logic             unused_wdata;
    assign unused_wdata = ^{csr_wdata[31:11], csr_wdata[9:8]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_addr <= '0;
            q_rd   <= 1'b0;
        end else begin
            q_addr <= csr_addr;
            q_rd   <= csr_read;
        end
    end

    assign sel       = (q_addr == CSR_ADDR);
    assign csr_valid = sel & (q_rd | (csr_modify != MOD_NONE));
    assign wr_req    = sel & (csr_modify == MOD_WRITE);
    assign clr_req   = sel & (csr_modify == MOD_CLEAR) & csr_wdata[UART_ST_OVF];
    assign fifo_push = wr_req & ~fifo_full;

    always_comb begin
        csr_rdata = '0;
        if (sel) begin
            csr_rdata[UART_ST_FULL] = fifo_full;
            csr_rdata[UART_ST_BUSY] = tx_busy;
            csr_rdata[UART_ST_OVF]  = ovf_q;
        end
    end

    // Full is judged on the registered count, so a same-cycle pop cannot rescue the byte.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                    ovf_q <= 1'b0;
        else if (wr_req && fifo_full) ovf_q <= 1'b1;
        else if (clr_req)             ovf_q <= 1'b0;
    end

    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (csr_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_busy = (fifo_count != '0) | (state_q != TX_IDLE);
    assign bit_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= TX_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) state_d = TX_DATA;
            end
            TX_DATA: begin
                if (bit_end && idx == 3'd7) state_d = TX_STOP;
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = TX_START;
                    end else begin
                        state_d  = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        uart_tx = 1'b1;
        case (state_q)
            TX_START: uart_tx = 1'b0;
            TX_DATA:  uart_tx = shift[0];
            default:  uart_tx = 1'b1;
        endcase
    end

    // Counter rests at zero in IDLE and wraps at bit_end, so START always begins at zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            baud_cnt <= '0;
            idx      <= '0;
            shift    <= '0;
        end else begin
            if (state_q == TX_IDLE || bit_end) baud_cnt <= '0;
            else                               baud_cnt <= baud_cnt + 1'b1;

            if (state_q == TX_START)              idx <= '0;
            else if (state_q == TX_DATA && bit_end) idx <= idx + 1'b1;

            if (fifo_pop)                           shift <= fifo_dout;
            else if (state_q == TX_DATA && bit_end) shift <= {1'b0, shift[7:1]};
        end
    end

endmodule
